// File: rtl/sram_2168_ctrl.sv
// Host req/ready front end for a 2168-style 4K x 4 SRAM. Sequences the address setup,
// CE_n/WE_n strobe and hold phases, and keeps the data pins free of drive contention.
`timescale 1ns/1ps
module sram_2168_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [11:0] i_addr,
  input  logic [3:0]  i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_rvalid,
  output logic [3:0]  o_rdata,
  output logic [11:0] o_a,
  output logic        o_ce_n,
  output logic        o_we_n,
  inout  wire  [3:0]  io_d
);

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StHold} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_wdata;
  logic [11:0] r_a;
  logic        r_ce_n;
  logic        r_we_n;
  logic        r_d_oe;
  logic        r_done;
  logic        r_rvalid;
  logic [3:0]  r_rdata;
  logic        w_last;

  assign w_last = (r_cnt == 4'd1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_wdata  <= 4'd0;
      r_a      <= 12'd0;
      r_ce_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_d_oe   <= 1'b0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 4'd0;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_req) begin
            r_we    <= i_we;
            r_a     <= i_addr;
            r_wdata <= i_wdata;
            r_cnt   <= SETUP_CYC[3:0];
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (w_last) begin
            r_state <= StActive;
            r_cnt   <= PULSE_CYC[3:0];
            r_ce_n  <= 1'b0;
            r_we_n  <= ~r_we;
            // Data is only driven on writes, so a read strobe never meets our own drive.
            r_d_oe  <= r_we;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StActive: begin
          if (w_last) begin
            r_state  <= StHold;
            r_cnt    <= HOLD_CYC[3:0];
            r_ce_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_done   <= 1'b1;
            r_rvalid <= ~r_we;
            if (!r_we) r_rdata <= io_d;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StHold: begin
          if (w_last) begin
            r_state <= StIdle;
            r_d_oe  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready  = (r_state == StIdle);
  assign o_done   = r_done;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_a      = r_a;
  assign o_ce_n   = r_ce_n;
  assign o_we_n   = r_we_n;
  assign io_d     = r_d_oe ? r_wdata : 4'bzzzz;

endmodule

// File: tb/tb_sram_2168_ctrl.sv
// Directed bench for sram_2168_ctrl: vector table against an SRAM model, plus reset,
// back-to-back, busy-input and non-default-timing sequences.
`timescale 1ns/1ps
module tb_sram_2168_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [11:0] addr = 12'd0;
  logic [3:0]  wdata = 4'd0;
  logic        ready, done, rvalid, ce_n, we_n;
  logic [3:0]  rdata;
  logic [11:0] a;
  wire  [3:0]  d;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [11:0] addr2 = 12'd0;
  logic [3:0]  wdata2 = 4'd0;
  logic        ready2, done2, rvalid2, ce_n2, we_n2;
  logic [3:0]  rdata2;
  logic [11:0] a2;
  wire  [3:0]  d2;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  sram_2168_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready), .o_done(done), .o_rvalid(rvalid), .o_rdata(rdata), .o_a(a),
    .o_ce_n(ce_n), .o_we_n(we_n), .io_d(d)
  );

  sram_2168_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_req(req2), .i_we(we2), .i_addr(addr2), .i_wdata(wdata2),
    .o_ready(ready2), .o_done(done2), .o_rvalid(rvalid2), .o_rdata(rdata2), .o_a(a2),
    .o_ce_n(ce_n2), .o_we_n(we_n2), .io_d(d2)
  );

  // SRAM model: drives D while read-selected, writes while CE_n and WE_n are both low.
  logic [3:0] mem [0:4095];
  assign d  = (!ce_n && we_n) ? mem[a] : 4'bzzzz;
  assign d2 = (!ce_n2 && we_n2) ? a2[3:0] : 4'bzzzz;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 4'd0;
    end else if (!ce_n && !we_n) begin
      mem[a] <= d;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) n_done++;
    if (!ce_n && we_n) chk("contention", {31'd0, dut.r_d_oe}, 32'd0);
    if (!ce_n2 && we_n2) chk("contention2", {31'd0, dut2.r_d_oe}, 32'd0);
  end

  int          res_tdone, res_tready, res_ndn;
  logic [3:0]  res_rd;
  logic        res_rv, res_d_ok, res_a_ok;
  logic [31:0] res_ce, res_we, res_oe;

  // One transaction from acceptance until ready returns; cycle k=1 is the first after E0.
  task automatic run_txn(input logic w, input logic [11:0] ad, input logic [3:0] wd,
                         input bit keep, input bit disturb);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    if (!ready) chk("ready_wait", {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; addr = ad; wdata = wd;
    res_tdone = -1; res_tready = -1; res_ndn = 0; res_rd = 4'hx; res_rv = 1'bx;
    res_d_ok = 1'b1; res_a_ok = 1'b1; res_ce = '0; res_we = '0; res_oe = '0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      if (!ce_n) res_ce[k] = 1'b1;
      if (!we_n) res_we[k] = 1'b1;
      if (dut.r_d_oe) res_oe[k] = 1'b1;
      if (dut.r_d_oe && d !== wd) res_d_ok = 1'b0;
      if (!ready && a !== ad) res_a_ok = 1'b0;
      if (done) begin
        res_ndn++;
        res_tdone = k;
        res_rd = rdata;
        res_rv = rvalid;
      end
      if (ready) begin
        res_tready = k;
        break;
      end
      if (!keep) req = (disturb && k < 4) ? (k[0] == 1'b0) : 1'b0;
      if (disturb && k < 4) begin
        addr = ~ad; wdata = ~wd; we = ~w;
      end
    end
    if (res_tready < 0) chk("txn_timeout", res_tready, 32'd5);
  endtask

  task automatic verify(input string tag, input logic w, input logic [3:0] exp_rd);
    chk({tag, "_done_lat"}, res_tdone, 32'd4);
    chk({tag, "_ready_lat"}, res_tready, 32'd5);
    chk({tag, "_done_cnt"}, res_ndn, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, res_rv}, {31'd0, ~w});
    chk({tag, "_rdata"}, {28'd0, res_rd}, {28'd0, exp_rd});
    chk({tag, "_ce_mask"}, res_ce, 32'h0000_000C);
    chk({tag, "_we_mask"}, res_we, w ? 32'h0000_000C : 32'h0);
    chk({tag, "_oe_mask"}, res_oe, w ? 32'h0000_001C : 32'h0);
    chk({tag, "_d_val"}, {31'd0, res_d_ok}, 32'd1);
    chk({tag, "_a_val"}, {31'd0, res_a_ok}, 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [11:0] ad;
    logic [3:0]  wd;
    logic [3:0]  exp_rd;
  } vec_t;

  vec_t vt [7];

  initial begin
    int dn0, t_rv, t_rdy;
    logic [3:0] rd2;

    // rdata holds the last read value across writes.
    vt[0] = '{1'b1, 12'h123, 4'hA, 4'h0};
    vt[1] = '{1'b0, 12'h123, 4'h0, 4'hA};
    vt[2] = '{1'b1, 12'h000, 4'h3, 4'hA};
    vt[3] = '{1'b1, 12'h800, 4'hC, 4'hA};
    vt[4] = '{1'b0, 12'h000, 4'h0, 4'h3};
    vt[5] = '{1'b0, 12'h800, 4'h0, 4'hC};
    vt[6] = '{1'b0, 12'h456, 4'h0, 4'h0};

    #1 reset = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_d_oe", {31'd0, dut.r_d_oe}, 32'd0);
    chk("rst_a", {20'd0, a}, 32'd0);
    chk("rst_rdata", {28'd0, rdata}, 32'd0);
    chk("rst_done", {30'd0, done, rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset while a write is in its ACTIVE phase.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 12'h2AA; wdata = 4'h7;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mid_pre_ce_n", {31'd0, ce_n}, 32'd0);
    dn0 = n_done;
    reset = 1'b1;
    #1;
    chk("mid_ce_n", {31'd0, ce_n}, 32'd1);
    chk("mid_we_n", {31'd0, we_n}, 32'd1);
    chk("mid_d_oe", {31'd0, dut.r_d_oe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_no_done", n_done, dn0);

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].w, vt[i].ad, vt[i].wd, 1'b0, 1'b0);
      verify($sformatf("vec%0d", i), vt[i].w, vt[i].exp_rd);
    end

    // req held high: alternating write/read of 0xFFF, ready every 5 cycles.
    for (int i = 0; i < 4; i++) begin
      run_txn((i % 2) == 0, 12'hFFF, 4'h5, 1'b1, 1'b0);
      verify($sformatf("b2b%0d", i), (i % 2) == 0, (i == 0) ? 4'h0 : 4'h5);
    end
    req = 1'b0;

    // Inputs toggled while busy must not disturb the latched transaction.
    run_txn(1'b1, 12'h321, 4'h6, 1'b0, 1'b1);
    verify("busy", 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_no_accept", {30'd0, ready, ce_n}, 32'd3);
    end
    run_txn(1'b0, 12'h321, 4'h0, 1'b0, 1'b0);
    verify("busy_rd", 1'b0, 4'h6);
    run_txn(1'b0, 12'hCDE, 4'h0, 1'b0, 1'b0);
    verify("busy_rd2", 1'b0, 4'h0);

    // Non-default timing: S=3, P=4, H=2.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; addr2 = 12'h00B;
    t_rv = -1; t_rdy = -1; rd2 = 4'hx;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      if (rvalid2 && t_rv < 0) begin
        t_rv = k;
        rd2 = rdata2;
      end
      if (ready2) begin
        t_rdy = k;
        break;
      end
      req2 = 1'b0;
    end
    chk("p2_read_lat", t_rv, 32'd8);
    chk("p2_rdata", {28'd0, rd2}, 32'hB);
    chk("p2_period", t_rdy, 32'd10);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
